// File: rtl/downcounter_jk.sv
// -----------------------------------------------------------------------------
// downcounter_jk
//   Modulo-MOD synchronous down counter whose state bits are individual JK
//   flip-flop cells. Counts MOD-1 down to 0 and wraps back to MOD-1.
//   Adds a synchronous parallel load (clamped to MOD-1), a count enable,
//   a combinational zero flag and a registered one-cycle borrow pulse.
//
// Parameters
//   WIDTH  number of count bits (1..16)
//   count modulus, parameter MOD (2..2**WIDTH)
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset (Q=0, borrow=0)
//   en        in   count enable; decrement on the clock edge when high
//   load      in   synchronous parallel load; has priority over en
//   load_val  in   [WIDTH-1:0] value loaded when load=1
//   Q         out  [WIDTH-1:0] current count
//   zero      out  combinational, high while Q==0
//   borrow    out  registered, one-cycle pulse after a 0 -> MOD-1 wrap
// -----------------------------------------------------------------------------

// Single JK storage cell with asynchronous active-high clear.
//   {j,k} = 00 hold, 01 clear, 10 set, 11 toggle.
module jk_ff (
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   // NOTE: sequential state is assigned with non-blocking (<=) so every
   // flop samples pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

endmodule

module downcounter_jk #(
   parameter int WIDTH = 3,
   parameter int MOD   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] Q,
   output logic             zero,
   output logic             borrow
);

   // Wrap / clamp value as a WIDTH-bit vector.
   localparam int             MAX_INT    = MOD - 1;
   localparam logic [WIDTH-1:0] MAX_VAL  = MAX_INT[WIDTH-1:0];

   // When the modulus fills the whole bit range, the wrap from 0 is just an
   // ordinary binary decrement (0 - 1 = all ones), so the toggle path handles it.
   localparam bit             FULL_RANGE = (MOD == 2 ** WIDTH);

   logic             q_is_zero;
   logic             use_toggle;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] low_zero;     // low_zero[i] = all bits below i are 0
   logic [WIDTH-1:0] next_val;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;

   assign q_is_zero    = (Q == '0);
   assign zero         = q_is_zero;
   assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

   // Decrement by toggling: a bit flips when every lower bit is 0.
   assign use_toggle = ~load & en & (~q_is_zero | FULL_RANGE);

   always_comb begin
      low_zero[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         low_zero[i] = low_zero[i-1] & ~Q[i-1];
      end
   end

   // NOTE: every output of this always_comb gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      next_val = Q;                      // hold
      if (load) begin
         next_val = load_clamped;
      end else if (en) begin
         next_val = MAX_VAL;             // wrap; only used when not toggling
      end

      if (use_toggle) begin
         j = low_zero;
         k = low_zero;
      end else begin
         // Drive each cell straight to next_val; hold gives j=k=0.
         j = next_val & ~Q;
         k = ~next_val & Q;
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      jk_ff u_cell (
         .clk   (clk),
         .reset (reset),
         .j     (j[g]),
         .k     (k[g]),
         .q     (Q[g])
      );
   end

   // Borrow marks the edge on which the counter wrapped from 0 to MOD-1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         borrow <= 1'b0;
      end else begin
         borrow <= ~load & en & q_is_zero;
      end
   end

endmodule

// File: tb/tb_downcounter_jk.sv
// -----------------------------------------------------------------------------
// tb_downcounter_jk
//   Four counter instances, (WIDTH,MOD) = (3,8), (3,6), (4,10), (1,2), share
//   clk/reset/en/load and take the low bits of a common load value. Directed
//   sequences check spelled-out values; a randomized phase compares every
//   instance against an arithmetic reference model each cycle.
// -----------------------------------------------------------------------------
module tb_downcounter_jk;

   localparam int N = 4;
   localparam int MODS   [N] = '{8, 6, 10, 2};
   localparam int WIDTHS [N] = '{3, 3, 4, 1};

   logic        clk;
   logic        reset;
   logic        en;
   logic        load;
   logic [15:0] lv;

   logic [2:0] q0, q1;
   logic [3:0] q2;
   logic [0:0] q3;
   logic       z0, z1, z2, z3;
   logic       b0, b1, b2, b3;

   int checks;
   int errors;

   // Reference model state
   int mq     [N];
   int mb     [N];
   int wraps  [N];
   int pulses [N];

   downcounter_jk #(.WIDTH(3), .MOD(8)) u_d0 (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(lv[2:0]),
      .Q(q0), .zero(z0), .borrow(b0));
   downcounter_jk #(.WIDTH(3), .MOD(6)) u_d1 (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(lv[2:0]),
      .Q(q1), .zero(z1), .borrow(b1));
   downcounter_jk #(.WIDTH(4), .MOD(10)) u_d2 (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(lv[3:0]),
      .Q(q2), .zero(z2), .borrow(b2));
   downcounter_jk #(.WIDTH(1), .MOD(2)) u_d3 (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(lv[0:0]),
      .Q(q3), .zero(z3), .borrow(b3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int dut_q(input int i);
      case (i)
         0: return int'(q0);
         1: return int'(q1);
         2: return int'(q2);
         default: return int'(q3);
      endcase
   endfunction

   function automatic int dut_z(input int i);
      case (i)
         0: return int'(z0);
         1: return int'(z1);
         2: return int'(z2);
         default: return int'(z3);
      endcase
   endfunction

   function automatic int dut_b(input int i);
      case (i)
         0: return int'(b0);
         1: return int'(b1);
         2: return int'(b2);
         default: return int'(b3);
      endcase
   endfunction

   // Behavioural next-state rules, applied at each rising edge.
   task automatic model_step();
      for (int i = 0; i < N; i++) begin
         if (reset) begin
            mq[i] = 0;
            mb[i] = 0;
         end else if (load) begin
            int v;
            v = int'(lv) % (1 << WIDTHS[i]);
            mq[i] = (v > MODS[i] - 1) ? MODS[i] - 1 : v;
            mb[i] = 0;
         end else if (en) begin
            if (mq[i] == 0) begin
               mq[i] = MODS[i] - 1;
               mb[i] = 1;
               wraps[i]++;
            end else begin
               mq[i] = mq[i] - 1;
               mb[i] = 0;
            end
         end else begin
            mb[i] = 0;
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mq[i] = 0;
         mb[i] = 0;
      end
   endtask

   // One clock: update model on the edge, then sample 1 time unit later.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic compare_all(input string phase);
      for (int i = 0; i < N; i++) begin
         check($sformatf("%s_q%0d", phase, i), dut_q(i), mq[i]);
         check($sformatf("%s_zero%0d", phase, i), dut_z(i), (mq[i] == 0) ? 1 : 0);
         check($sformatf("%s_borrow%0d", phase, i), dut_b(i), mb[i]);
         check($sformatf("%s_range%0d", phase, i), (dut_q(i) < MODS[i]) ? 1 : 0, 1);
         if (dut_b(i) == 1) pulses[i]++;
      end
   endtask

   int seq8 [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
   int seq6 [6] = '{3, 2, 1, 0, 5, 4};

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      en     = 1'b0;
      load   = 1'b0;
      lv     = '0;
      model_reset();
      for (int i = 0; i < N; i++) begin
         wraps[i]  = 0;
         pulses[i] = 0;
      end

      // Reset state
      #2;
      check("rst_q0", int'(q0), 0);
      check("rst_zero0", int'(z0), 1);
      check("rst_borrow0", int'(b0), 0);
      cycle();
      compare_all("rst");

      // First instance (modulus 8): free-running countdown from reset, 9 edges
      reset = 1'b0;
      en    = 1'b1;
      for (int n = 0; n < 9; n++) begin
         cycle();
         check($sformatf("seq8_q_%0d", n), int'(q0), seq8[n]);
         check($sformatf("seq8_borrow_%0d", n), int'(b0), (n == 0 || n == 8) ? 1 : 0);
         check($sformatf("seq8_zero_%0d", n), int'(z0), (seq8[n] == 0) ? 1 : 0);
      end

      // Second instance (modulus 6): load 4, then count through the wrap
      en   = 1'b0;
      load = 1'b1;
      lv   = 16'd4;
      cycle();
      check("ld4_q1", int'(q1), 4);
      load = 1'b0;
      en   = 1'b1;
      for (int n = 0; n < 6; n++) begin
         cycle();
         check($sformatf("seq6_q_%0d", n), int'(q1), seq6[n]);
         check($sformatf("seq6_borrow_%0d", n), int'(b1), (n == 4) ? 1 : 0);
      end

      // Out-of-range load clamps to MOD-1
      en   = 1'b0;
      load = 1'b1;
      lv   = 16'd7;
      cycle();
      check("clamp_q1", int'(q1), 5);
      check("clamp_borrow1", int'(b1), 0);
      check("noclamp_q0", int'(q0), 7);

      // Load beats en at Q==0
      lv = 16'd0;
      cycle();
      check("ld0_q0", int'(q0), 0);
      en = 1'b1;
      lv = 16'd3;
      cycle();
      check("ldpri_q0", int'(q0), 3);
      check("ldpri_borrow0", int'(b0), 0);
      load = 1'b0;
      en   = 1'b0;
      for (int n = 0; n < 4; n++) begin
         cycle();
         check($sformatf("hold_q0_%0d", n), int'(q0), 3);
         check($sformatf("hold_zero0_%0d", n), int'(z0), 0);
      end

      // Wrap to 5 with borrow high, then async reset mid-cycle
      load = 1'b1;
      lv   = 16'd0;
      cycle();
      load = 1'b0;
      en   = 1'b1;
      cycle();
      check("prerst_q1", int'(q1), 5);
      check("prerst_borrow1", int'(b1), 1);
      #3;
      reset = 1'b1;
      model_reset();
      #1;
      check("async_q1", int'(q1), 0);
      check("async_zero1", int'(z1), 1);
      check("async_borrow1", int'(b1), 0);
      for (int n = 0; n < 2; n++) begin
         cycle();
         compare_all("inrst");
      end
      reset = 1'b0;
      cycle();
      check("rel_q1", int'(q1), 5);
      check("rel_borrow1", int'(b1), 1);
      check("rel_q0", int'(q0), 7);
      compare_all("rel");

      // Randomized phase against the reference model
      for (int i = 0; i < N; i++) begin
         wraps[i]  = 0;
         pulses[i] = 0;
      end
      for (int n = 0; n < 2000; n++) begin
         en   = ($urandom_range(0, 3) != 0);
         load = ($urandom_range(0, 15) == 0);
         lv   = 16'($urandom);
         cycle();
         compare_all("rnd");
      end
      for (int i = 0; i < N; i++) begin
         check($sformatf("pulses%0d", i), pulses[i], wraps[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
